// File: rtl/mem_write_checker.sv
// +--------------------------------------------------------------------------+
// | mem_write_checker : ordered store-sequence checker with scratch window    |
// | and cycle budget for the single-cycle MIPS data-memory write port.        |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_write_checker #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [IDX_W:0]    cfg_num,
  input  logic              ign_en,
  input  logic [ADDR_W-1:0] ign_base,
  input  logic [ADDR_W-1:0] ign_mask,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [IDX_W:0]    match_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [CNT_W-1:0]  cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  localparam logic [1:0]     CODE_NONE    = 2'd0;
  localparam logic [1:0]     CODE_UNEXP   = 2'd1;
  localparam logic [1:0]     CODE_TIMEOUT = 2'd2;
  localparam logic [IDX_W:0] DEPTH_N      = (IDX_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] TIMEOUT_N  = CNT_W'(TIMEOUT);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [IDX_W:0]    num, num_nxt;
  logic [IDX_W:0]    match_nxt;
  logic [CNT_W-1:0]  cycles_nxt;
  logic [1:0]        code_nxt;
  logic [ADDR_W-1:0] faddr_nxt;
  logic [DATA_W-1:0] fdata_nxt;

  logic [ADDR_W-1:0] exp_addr [DEPTH];
  logic [DATA_W-1:0] exp_data [DEPTH];

  logic hit, in_window;

  // Table entries are writable only while idle, so a running check never sees them move.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        exp_addr[i] <= '0;
        exp_data[i] <= '0;
      end else if (state == IDLE && cfg_we && cfg_idx == IDX_W'(i)) begin
        exp_addr[i] <= cfg_addr;
        exp_data[i] <= cfg_data;
      end
    end
  end

  assign hit       = mem_write && data_addr == exp_addr[ptr] && write_data == exp_data[ptr];
  assign in_window = mem_write && ign_en && ((data_addr & ign_mask) == (ign_base & ign_mask));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      num       <= '0;
      match_cnt <= '0;
      cycles    <= '0;
      fail_code <= CODE_NONE;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      num       <= num_nxt;
      match_cnt <= match_nxt;
      cycles    <= cycles_nxt;
      fail_code <= code_nxt;
      fail_addr <= faddr_nxt;
      fail_data <= fdata_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    num_nxt    = num;
    match_nxt  = match_cnt;
    cycles_nxt = cycles;
    code_nxt   = fail_code;
    faddr_nxt  = fail_addr;
    fdata_nxt  = fail_data;
    case (state)
      RUN: begin
        cycles_nxt = cycles + CNT_W'(1);
        if (num == '0) begin
          state_nxt = PASS;
        end else if (hit) begin
          ptr_nxt   = ptr + IDX_W'(1);
          match_nxt = match_cnt + (IDX_W+1)'(1);
          if (match_nxt == num) state_nxt = PASS;
        end else if (in_window) begin
          state_nxt = RUN;
        end else if (mem_write) begin
          state_nxt = FAIL;
          code_nxt  = CODE_UNEXP;
          faddr_nxt = data_addr;
          fdata_nxt = write_data;
        end else if (cycles_nxt == TIMEOUT_N) begin
          state_nxt = FAIL;
          code_nxt  = CODE_TIMEOUT;
        end
      end
      default: begin
        // IDLE, PASS and FAIL all accept a (re)start with the current table.
        if (start) begin
          state_nxt  = RUN;
          ptr_nxt    = '0;
          match_nxt  = '0;
          cycles_nxt = '0;
          code_nxt   = CODE_NONE;
          faddr_nxt  = '0;
          fdata_nxt  = '0;
          num_nxt    = (cfg_num > DEPTH_N) ? DEPTH_N : cfg_num;
        end
      end
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == PASS) || (state == FAIL);
  assign pass = (state == PASS);

endmodule

`default_nettype wire

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesizable, parametrised store-sequence checker for the single-cycle MIPS core. It sits beside the core on the data-memory write port and compares every store against a programmable ordered table of expected (address, data) pairs. Stores that fall in a programmable scratch window are tolerated, and a cycle budget is enforced. It reports pass/fail with diagnostics, so self-checking runs no longer depend on a hard-coded single-address testbench.

## Interface
- DATA_W, 32, store data width
- ADDR_W, 32, store address width
- DEPTH, 4, expected-table entries (power of two, ≥2); IDX_W = $clog2(DEPTH)
- TIMEOUT, 1024, max RUN cycles before timeout failure (≥2)
- CNT_W, 16, cycle-counter width (2^CNT_W > TIMEOUT)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- mem_write  in  1  store strobe from core
- data_addr  in  ADDR_W  store address
- write_data  in  DATA_W  store data
- cfg_we  in  1  table write enable (honoured only in IDLE)
- cfg_idx  in  IDX_W  table entry index
- cfg_addr  in  ADDR_W  expected address for entry
- cfg_data  in  DATA_W  expected data for entry
- cfg_num  in  IDX_W+1  number of active entries, latched at start
- ign_en  in  1  enable scratch window
- ign_base  in  ADDR_W  scratch window base
- ign_mask  in  ADDR_W  window compare mask
- start  in  1  begin or re-begin a check run
- busy  out  1  high in RUN
- done  out  1  high in PASS or FAIL
- pass  out  1  high in PASS only
- fail_code  out  2  0 none, 1 unexpected store, 2 timeout
- match_cnt  out  IDX_W+1  expected entries matched so far
- fail_addr  out  ADDR_W  address of offending store
- fail_data  out  DATA_W  data of offending store
- cycles  out  CNT_W  RUN cycles elapsed

## Operation
- FSM states: IDLE, RUN, PASS, FAIL. Reset gives IDLE. All outputs are 0 and all table entries are 0.
- IDLE:
  - cfg_we writes entry cfg_idx.
  - start moves to RUN. It clears ptr, match_cnt, cycles, fail_code, fail_addr and fail_data, and latches num = min(cfg_num, DEPTH).
- start in PASS/FAIL behaves as in IDLE: it re-runs with the existing table. start in RUN is ignored.
- cfg_we outside IDLE is ignored. The table does not change.
- RUN, evaluated every rising edge:
  - cycles increments.
  - If num==0, go to PASS on the first RUN edge (vacuous).
  - If mem_write and data_addr==exp_addr[ptr] and write_data==exp_data[ptr]: match.
    - ptr and match_cnt increment.
    - If match_cnt+1==num, go to PASS.
  - Else if mem_write, ign_en, and (data_addr&ign_mask)==(ign_base&ign_mask): no action.
  - Else if mem_write: go to FAIL with code 1. Capture data_addr and write_data.
  - Else if cycles+1==TIMEOUT: go to FAIL with code 2. fail_addr and fail_data stay 0.
- Priority at one edge: expected match > ignore > unexpected > timeout.
  - A completing match on the TIMEOUT edge yields PASS.
  - An unexpected store on that edge yields code 1.
- PASS/FAIL are terminal. All outputs hold (cycles frozen) until start or reset.
- Matching is strictly in table order. A correct pair at the wrong position is unexpected unless it lies in the scratch window.

## Timing
- All outputs are registered. The effect of a store sampled at edge N is visible after edge N.
- start sampled at edge S gives busy=1 after S. The first evaluated store is sampled at edge S+1.
- Timeout: with no stores, FAIL occurs at edge S+TIMEOUT, with cycles=TIMEOUT.
- Reset assertion mid-run forces IDLE and zeroes outputs and table immediately, without waiting for clk. Release is synchronous to the next edge.
- No handshake back-pressure: the checker never stalls the core.

## Test plan
- Table {0:(84,7)}, num=1, ign_en=1, ign_base=80, mask=all-ones. Start, then stores (80,5),(84,7). Expect pass=1, done=1, match_cnt=1, fail_code=0.
- Same table, stores (80,5),(88,3). Expect FAIL, fail_code=1, fail_addr=88, fail_data=3, match_cnt=0.
- Table {(4,1),(8,2),(12,3),(16,4)}, num=4. In-order stores give PASS with match_cnt=4. Re-start and issue (4,1),(12,3). Expect FAIL code 1 at the second store, match_cnt=1.
- TIMEOUT=16, num=1, no stores. Expect FAIL, code 2, cycles=16, fail_addr=0. The final match sampled exactly on edge S+16 instead yields PASS.
- Assert reset 3 cycles into RUN. Expect all outputs 0 immediately. After release, start with num=1 and store (0,0): PASS, since table entries reset to 0.
- cfg_we pulses (idx 0, 84, 9) during RUN are ignored. Store (84,7) with the original table still passes. num=0 gives PASS one edge after start.
